spike_count_classifier: RTL and testbench

Output stage that sits directly downstream of the 5-neuron first spiking layer. It counts each neuron's output spikes over a fixed inference window of timestep pulses. When the window closes, it scans the counts and reports the winning neuron index as the classified result. One inference runs per start request; the result holds until the next start.

---
 rtl/snn_pkg.sv | 23 ++
 rtl/sat_counter.sv | 26 ++
 rtl/spike_count_classifier.sv | 180 ++++++++++++++++++
 tb/tb_spike_count_classifier.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-layer blocks: FSM encoding, default
// layer geometry and the index-width helper.
package snn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int N_OUT_DEF = 5;
  localparam int CNT_W_DEF = 8;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Counts per-neuron spikes over a window of timestep pulses, then scans the counts
// for the winner (lowest index on ties); result fields hold until the next start.
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int N_OUT   = N_OUT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WINDOW  = 100,
  parameter int SPK_DLY = 1,
  parameter int IDX_W   = clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             start,
  input  logic [N_OUT-1:0] spike,
  output logic             busy,
  output logic             done,
  output logic             class_valid,
  output logic [IDX_W-1:0] class_id,
  output logic [CNT_W-1:0] max_count,
  output logic             tie
);

  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start_acc;
  logic             w_samp;
  logic             w_cnt_en;
  logic             w_busy;
  logic [15:0]      r_win;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] w_best_idx;
  logic [IDX_W-1:0] r_class_id;
  logic [CNT_W-1:0] r_best_cnt;
  logic [CNT_W-1:0] w_best_cnt;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] w_cur;
  logic             r_tie_acc;
  logic             w_tie;
  logic             r_tie;
  logic             r_valid;
  logic             r_done;
  logic [CNT_W-1:0] w_cnt [N_OUT];

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_cnt_en    = (r_state == S_COUNT) && w_samp;

  // Align the strobe with the upstream layer's registered spike output.
  generate
    if (SPK_DLY == 0) begin : g_nodly
      assign w_samp = pulse;
    end else begin : g_dly
      logic [SPK_DLY-1:0] r_dly;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dly <= '0;
        end else if (w_start_acc) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= pulse;
          for (int k = 1; k < SPK_DLY; k++) r_dly[k] <= r_dly[k-1];
        end
      end
      assign w_samp = r_dly[SPK_DLY-1];
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start_acc),
        .en    (w_cnt_en && spike[i]),
        .q     (w_cnt[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_COUNT;
      S_COUNT: begin
        w_busy = 1'b1;
        if (w_samp && (r_win == WIN_LAST)) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Index 0 seeds the running max; later indices need strictly greater to win.
  assign w_cur = w_cnt[r_idx];

  always_comb begin
    w_best_cnt = r_best_cnt;
    w_best_idx = r_best_idx;
    w_tie      = r_tie_acc;
    if (r_idx == '0) begin
      w_best_cnt = w_cur;
      w_best_idx = '0;
      w_tie      = 1'b0;
    end else if (w_cur > r_best_cnt) begin
      w_best_cnt = w_cur;
      w_best_idx = r_idx;
      w_tie      = 1'b0;
    end else if (w_cur == r_best_cnt) begin
      w_tie      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win      <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
      r_tie_acc  <= 1'b0;
      r_class_id <= '0;
      r_max      <= '0;
      r_tie      <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_win   <= '0;
            r_valid <= 1'b0;
            r_tie   <= 1'b0;
          end
        end
        S_COUNT: begin
          r_idx <= '0;
          if (w_samp) r_win <= r_win + 16'd1;
        end
        S_SCAN: begin
          r_idx      <= r_idx + 1'b1;
          r_best_cnt <= w_best_cnt;
          r_best_idx <= w_best_idx;
          r_tie_acc  <= w_tie;
          // Publish on the final scan step so the fields are valid alongside done.
          if (r_idx == IDX_LAST) begin
            r_class_id <= w_best_idx;
            r_max      <= w_best_cnt;
            r_tie      <= w_tie;
            r_valid    <= 1'b1;
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign class_valid = r_valid;
  assign class_id    = r_class_id;
  assign max_count   = r_max;
  assign tie         = r_tie;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Scoreboard bench: three classifier instances (window 4, window 8, 3-bit counters
// with window 12); expected results are queued as stimulus is driven.
module tb_spike_count_classifier;

  typedef struct {
    int d;
    int id;
    int mx;
    bit tie;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_i [3];
  logic       start_i [3];
  logic [4:0] spike_i [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       valid_o [3];
  logic [2:0] id_o    [3];
  logic [7:0] max_o   [3];
  logic       tie_o   [3];
  logic [2:0] max_c;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   win_of  [3] = '{4, 8, 12};
  int   cmax_of [3] = '{255, 255, 7};
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign max_o[2] = {5'd0, max_c};

  spike_count_classifier #(.N_OUT(5), .CNT_W(8), .WINDOW(4), .SPK_DLY(1), .IDX_W(3)) u_a (
    .clk(clk), .reset(reset), .pulse(pulse_i[0]), .start(start_i[0]), .spike(spike_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .class_valid(valid_o[0]), .class_id(id_o[0]),
    .max_count(max_o[0]), .tie(tie_o[0]));

  spike_count_classifier #(.N_OUT(5), .CNT_W(8), .WINDOW(8), .SPK_DLY(1), .IDX_W(3)) u_b (
    .clk(clk), .reset(reset), .pulse(pulse_i[1]), .start(start_i[1]), .spike(spike_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .class_valid(valid_o[1]), .class_id(id_o[1]),
    .max_count(max_o[1]), .tie(tie_o[1]));

  spike_count_classifier #(.N_OUT(5), .CNT_W(3), .WINDOW(12), .SPK_DLY(1), .IDX_W(3)) u_c (
    .clk(clk), .reset(reset), .pulse(pulse_i[2]), .start(start_i[2]), .spike(spike_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .class_valid(valid_o[2]), .class_id(id_o[2]),
    .max_count(max_c), .tie(tie_o[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int d, input string tag);
    total++;
    if ({busy_o[d], done_o[d], valid_o[d], id_o[d], max_o[d], tie_o[d]} !== 16'd0)
      begin
      bad++;
      $display("FAIL %s dut%0d: busy=%b done=%b valid=%b id=%0d max=%0d tie=%b, want all 0",
               tag, d, busy_o[d], done_o[d], valid_o[d], id_o[d], max_o[d], tie_o[d]);
    end
  endtask

  // Drive one inference: gap = idle cycles between pulses (0 = back-to-back).
  // Only spikes one cycle after a pulse (the samp cycle) enter the model.
  task automatic run_inf(input int d, input logic [4:0] vec [12], input int gap,
                         input bit coinc, input bit mid_start, input bit abort,
                         input string name);
    int   win, acc, sent, g, cf, dc, mx, id;
    logic prev;
    bit   got, tie_e;
    int   m [5];
    exp_t e;
    win = win_of[d];
    acc = 0; sent = 0; g = 0; cf = 0; dc = 0; prev = 1'b0; got = 1'b0;
    for (int j = 0; j < 5; j++) m[j] = 0;

    start_i[d] = 1'b1;
    pulse_i[d] = coinc;
    spike_i[d] = 5'b11111;
    tick();
    for (int it = 0; acc < win; it++) begin
      if (it == 0) begin
        total++;
        if (busy_o[d] !== 1'b1) begin
          bad++;
          $display("FAIL %s busy_in_count: got %b want 1", name, busy_o[d]);
        end
      end
      pulse_i[d] = (sent < win) && (g == 0);
      if (pulse_i[d]) begin
        sent++;
        g = gap;
      end else if (g > 0) begin
        g--;
      end
      if (prev) begin
        spike_i[d] = vec[acc];
        for (int j = 0; j < 5; j++)
          if (vec[acc][j] && m[j] < cmax_of[d]) m[j]++;
        acc++;
        cf = cyc;
      end else begin
        spike_i[d] = 5'($urandom);
      end
      start_i[d] = mid_start && (sent == 2);
      prev = pulse_i[d];
      tick();
    end
    pulse_i[d] = 1'b0;
    start_i[d] = 1'b0;
    spike_i[d] = 5'b00000;

    if (abort) begin
      total++;
      if (busy_o[d] !== 1'b1) begin
        bad++;
        $display("FAIL %s busy_in_scan: got %b want 1", name, busy_o[d]);
      end
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) check_zero(k, {name, "_async_reset"});
      @(negedge clk);
      reset = 1'b0;
      tick();
      return;
    end

    mx = -1; id = 0; tie_e = 1'b0;
    for (int j = 0; j < 5; j++)
      if (m[j] > mx) begin
        mx = m[j];
        id = j;
      end
    for (int j = 0; j < 5; j++)
      if (j != id && m[j] == mx) tie_e = 1'b1;
    sb.push_back('{d: d, id: id, mx: mx, tie: tie_e});

    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done_o[d] === 1'b1) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    e = sb.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s done_timeout: no done within 40 cycles", name);
      return;
    end
    if (dc - cf !== 6) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles want 6", name, dc - cf);
    end
    total++;
    if (id_o[e.d] !== 3'(e.id) || max_o[e.d] !== 8'(e.mx) || tie_o[e.d] !== e.tie) begin
      bad++;
      $display("FAIL %s result: got id=%0d max=%0d tie=%b want id=%0d max=%0d tie=%b",
               name, id_o[e.d], max_o[e.d], tie_o[e.d], e.id, e.mx, e.tie);
    end
    total++;
    if (valid_o[d] !== 1'b1 || busy_o[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s valid_at_done: got valid=%b busy=%b want 1/0", name, valid_o[d],
               busy_o[d]);
    end
    @(negedge clk);
    total++;
    if (done_o[d] !== 1'b0 || valid_o[d] !== 1'b1 || id_o[d] !== 3'(e.id)) begin
      bad++;
      $display("FAIL %s hold_after_done: got done=%b valid=%b id=%0d want 0/1/%0d", name,
               done_o[d], valid_o[d], id_o[d], e.id);
    end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      pulse_i[d] = 1'b0;
      start_i[d] = 1'b0;
      spike_i[d] = 5'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_zero(d, "reset_state");
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [4:0] v [12];
    for (int k = 0; k < 12; k++) v[k] = 5'b00100;
    run_inf(0, v, 1, 1'b0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_tie;
    logic [4:0] v [12];
    v = '{5'b00011, 5'b00111, 5'b00111, 5'b00110, 5'b00110, 5'b01110, 5'b00110,
          5'b00100, 5'b0, 5'b0, 5'b0, 5'b0};
    run_inf(1, v, 2, 1'b0, 1'b0, 1'b0, "tie");
  endtask

  task automatic test_zero;
    logic [4:0] v [12];
    for (int k = 0; k < 12; k++) v[k] = 5'b00000;
    run_inf(1, v, 0, 1'b0, 1'b0, 1'b0, "all_zero");
  endtask

  task automatic test_saturate;
    logic [4:0] v [12];
    for (int k = 0; k < 12; k++) v[k] = (k < 3) ? 5'b10001 : 5'b10000;
    run_inf(2, v, 0, 1'b0, 1'b0, 1'b0, "saturate");
  endtask

  task automatic test_ignore;
    logic [4:0] v [12];
    for (int k = 0; k < 12; k++) v[k] = 5'($urandom);
    run_inf(1, v, 1, 1'b1, 1'b1, 1'b0, "ignore_start_junk");
    for (int k = 0; k < 12; k++) v[k] = 5'($urandom);
    run_inf(2, v, 3, 1'b1, 1'b1, 1'b0, "ignore_start_gap3");
  endtask

  task automatic test_back_to_back;
    logic [4:0] v [12];
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 12; k++) v[k] = 5'($urandom);
      run_inf(0, v, 0, 1'b0, 1'b0, 1'b0, "back_to_back");
    end
  endtask

  task automatic test_reset_scan;
    logic [4:0] v [12];
    for (int k = 0; k < 12; k++) v[k] = 5'b01000;
    run_inf(0, v, 0, 1'b0, 1'b0, 1'b1, "reset_scan");
    v = '{5'b00010, 5'b00011, 5'b00010, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0,
          5'b0, 5'b0};
    run_inf(0, v, 1, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_zero();
    test_saturate();
    test_ignore();
    test_back_to_back();
    test_reset_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
